// File: rtl/sram_rw_ctrl.sv
// Single-port SRAM front end: zero-fills the array after reset, then arbitrates
// write/read requests onto the RW0 port and returns read data through a credited FIFO.
//
// state   | meaning
// ST_INIT | zero-fill sweep, one word per cycle, request channels closed
// ST_RUN  | round-robin request arbitration, read responses via FIFO
module sram_rw_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata,
    output logic              init_done
);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(RESP_DEPTH - 1);
    localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(RESP_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic                r_init_done;
    logic                r_pending;
    logic                r_last_rd;
    logic [DATA_W-1:0]   r_fifo [RESP_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [CNT_W:0]      w_used;
    logic                w_credit;
    logic                w_wr_elig;
    logic                w_rd_elig;
    logic                w_rd_win;
    logic                w_wr_gnt;
    logic                w_rd_gnt;
    logic                w_push;
    logic                w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts only registered occupancy; a pop in this cycle frees nothing yet.
    assign w_used     = {{CNT_W{1'b0}}, r_pending} + {1'b0, r_count};
    assign w_credit   = (w_used < DEPTH_EXT);
    assign w_push     = r_pending;
    assign resp_valid = (r_count != '0);
    assign w_pop      = resp_valid && resp_ready;
    assign resp_data  = r_fifo[r_rd_ptr];
    assign init_done  = r_init_done;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_elig   = 1'b0;
        w_rd_elig   = 1'b0;
        w_rd_win    = 1'b0;
        w_wr_gnt    = 1'b0;
        w_rd_gnt    = 1'b0;
        w_ready     = 1'b0;
        r_ready     = 1'b0;
        RW0_en      = 1'b0;
        RW0_wmode   = 1'b0;
        RW0_addr    = '0;
        RW0_wdata   = '0;
        case (r_state)
            ST_INIT: begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = r_init_cnt;
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_wr_elig = w_valid;
                w_rd_elig = r_valid && w_credit;
                w_rd_win  = w_rd_elig && (!w_wr_elig || !r_last_rd);
                w_ready   = !w_rd_win;
                r_ready   = w_rd_win;
                w_wr_gnt  = w_valid && !w_rd_win;
                w_rd_gnt  = w_rd_win;
                if (w_wr_gnt) begin
                    RW0_en    = 1'b1;
                    RW0_wmode = 1'b1;
                    RW0_addr  = w_addr;
                    RW0_wdata = w_data;
                end else if (w_rd_gnt) begin
                    RW0_en   = 1'b1;
                    RW0_addr = r_addr;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        // Hold the SRAM and both channels quiet for as long as reset is held.
        if (!reset_n) begin
            RW0_en    = 1'b0;
            RW0_wmode = 1'b0;
            w_ready   = 1'b0;
            r_ready   = 1'b0;
            w_wr_gnt  = 1'b0;
            w_rd_gnt  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_pending   <= 1'b0;
            r_last_rd   <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_rd_gnt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + ADDR_W'(1);
            end
            if ((r_state == ST_INIT) && (w_state_nxt == ST_RUN)) begin
                r_init_done <= 1'b1;
            end
            if (w_wr_gnt) begin
                r_last_rd <= 1'b0;
            end else if (w_rd_gnt) begin
                r_last_rd <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Response payload needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= RW0_rdata;
        end
    end

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed bench for sram_rw_ctrl: a depth-2 instance for the main flow and a
// small depth-3 instance for streaming throughput and mid-operation reset.
module tb_sram_rw_ctrl;
    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int AW3 = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    logic          reset_n, w_valid, r_valid, resp_ready;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] w_data;
    logic          w_ready, r_ready, resp_valid, init_done;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] RW0_addr;
    logic          RW0_en, RW0_wmode;
    logic [DW-1:0] RW0_wdata, RW0_rdata;

    logic           reset_n3, w_valid3, r_valid3, resp_ready3;
    logic [AW3-1:0] w_addr3, r_addr3;
    logic [DW-1:0]  w_data3;
    logic           w_ready3, r_ready3, resp_valid3, init_done3;
    logic [DW-1:0]  resp_data3;
    logic [AW3-1:0] RW0_addr3;
    logic           RW0_en3, RW0_wmode3;
    logic [DW-1:0]  RW0_wdata3, RW0_rdata3;

    sram_rw_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata), .init_done(init_done)
    );

    sram_rw_ctrl #(.ADDR_W(AW3), .DATA_W(DW), .RESP_DEPTH(3)) dut3 (
        .clock(clock), .reset_n(reset_n3),
        .w_valid(w_valid3), .w_ready(w_ready3), .w_addr(w_addr3), .w_data(w_data3),
        .r_valid(r_valid3), .r_ready(r_ready3), .r_addr(r_addr3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3),
        .RW0_addr(RW0_addr3), .RW0_en(RW0_en3), .RW0_wmode(RW0_wmode3),
        .RW0_wdata(RW0_wdata3), .RW0_rdata(RW0_rdata3), .init_done(init_done3)
    );

    // SRAM behavioural models: read data one cycle after enable.
    logic [DW-1:0] sram  [2**AW];
    logic [DW-1:0] sram3 [2**AW3];
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) sram[RW0_addr] <= RW0_wdata;
            else           RW0_rdata <= sram[RW0_addr];
        end
        if (RW0_en3) begin
            if (RW0_wmode3) sram3[RW0_addr3] <= RW0_wdata3;
            else            RW0_rdata3 <= sram3[RW0_addr3];
        end
    end

    logic [DW-1:0] exp_mem  [2**AW];
    logic [DW-1:0] exp_mem3 [2**AW3];
    logic [DW-1:0] sbq[$];
    logic [DW-1:0] sbq3[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: expected read data pushed at the read handshake, popped on response.
    always @(negedge clock) begin
        if (reset_n) begin
            if (w_valid && w_ready) exp_mem[w_addr] = w_data;
            if (r_valid && r_ready) sbq.push_back(exp_mem[r_addr]);
            if (resp_valid && resp_ready) begin
                check("resp_expected", 64'(sbq.size() > 0), 64'd1);
                if (sbq.size() > 0) check("resp_data", resp_data, sbq.pop_front());
            end
        end
        if (reset_n3) begin
            if (w_valid3 && w_ready3) exp_mem3[w_addr3] = w_data3;
            if (r_valid3 && r_ready3) sbq3.push_back(exp_mem3[r_addr3]);
            if (resp_valid3 && resp_ready3) begin
                check("resp3_expected", 64'(sbq3.size() > 0), 64'd1);
                if (sbq3.size() > 0) check("resp3_data", resp_data3, sbq3.pop_front());
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit last);
        int n = 0;
        @(posedge clock); #1;
        w_valid = 1'b1; w_addr = a; w_data = d;
        do begin @(negedge clock); n++; end while (!w_ready && n < 32);
        check("wr_accept", w_ready, 1);
        if (last) begin @(posedge clock); #1; w_valid = 1'b0; end
    endtask

    task automatic rd(input logic [AW-1:0] a, input bit last);
        int n = 0;
        @(posedge clock); #1;
        r_valid = 1'b1; r_addr = a;
        do begin @(negedge clock); n++; end while (!r_ready && n < 32);
        check("rd_accept", r_ready, 1);
        if (last) begin @(posedge clock); #1; r_valid = 1'b0; end
    endtask

    task automatic wr3(input logic [AW3-1:0] a, input logic [DW-1:0] d, input bit last);
        int n = 0;
        @(posedge clock); #1;
        w_valid3 = 1'b1; w_addr3 = a; w_data3 = d;
        do begin @(negedge clock); n++; end while (!w_ready3 && n < 32);
        check("wr3_accept", w_ready3, 1);
        if (last) begin @(posedge clock); #1; w_valid3 = 1'b0; end
    endtask

    task automatic rd3(input logic [AW3-1:0] a, input bit last);
        int n = 0;
        @(posedge clock); #1;
        r_valid3 = 1'b1; r_addr3 = a;
        do begin @(negedge clock); n++; end while (!r_ready3 && n < 32);
        check("rd3_accept", r_ready3, 1);
        if (last) begin @(posedge clock); #1; r_valid3 = 1'b0; end
    endtask

    task automatic drain(input bit second);
        int n = 0;
        while (((second ? sbq3.size() : sbq.size()) != 0) && n < 64) begin
            @(negedge clock); n++;
        end
        check(second ? "drain3" : "drain", second ? sbq3.size() : sbq.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b0;
        w_addr = '0; r_addr = '0; w_data = '0;
        reset_n3 = 1'b0; w_valid3 = 1'b0; r_valid3 = 1'b0; resp_ready3 = 1'b0;
        w_addr3 = '0; r_addr3 = '0; w_data3 = '0;
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
        for (int i = 0; i < 2**AW3; i++) exp_mem3[i] = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rw0_en", RW0_en, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_r_ready", r_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst3_rw0_en", RW0_en3, 0);

        // Zero-fill sweep: one write per cycle, addresses 0..2^AW-1.
        @(posedge clock); #1;
        reset_n = 1'b1; reset_n3 = 1'b1;
        for (int i = 0; i < 2**AW; i++) begin
            @(negedge clock);
            check("init_word",
                  {RW0_en, RW0_wmode, w_ready, r_ready, resp_valid, init_done, RW0_addr, RW0_wdata},
                  {6'b110000, AW'(i), 32'h0});
        end
        @(negedge clock);
        check("init_done", init_done, 1);
        check("run_idle_en", RW0_en, 0);
        check("run_idle_w_ready", w_ready, 1);
        check("run_idle_r_ready", r_ready, 0);

        resp_ready = 1'b1;
        rd(14'h1234, 1'b1);
        drain(1'b0);

        // Read-after-write and two-cycle response latency.
        wr(14'h0005, 32'hDEAD_BEEF, 1'b1);
        rd(14'h0005, 1'b0);
        @(posedge clock); #1; r_valid = 1'b0;
        @(negedge clock);
        check("lat_cycle1_resp_valid", resp_valid, 0);
        @(negedge clock);
        check("lat_cycle2_resp_valid", resp_valid, 1);
        check("lat_cycle2_resp_data", resp_data, 32'hDEAD_BEEF);
        drain(1'b0);

        // Both channels held valid: grants alternate starting with write.
        @(posedge clock); #1;
        w_valid = 1'b1; w_addr = 14'h0100; w_data = 32'h0000_0100;
        r_valid = 1'b1; r_addr = 14'h0200;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("rr_grant", {w_ready, r_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        @(posedge clock); #1; w_valid = 1'b0; r_valid = 1'b0;
        drain(1'b0);

        // Credit limit with resp_ready low, then in-order release.
        for (int k = 0; k < 4; k++) wr(AW'(16 + k), 32'hCAFE_0000 | k, k == 3);
        resp_ready = 1'b0;
        rd(14'h0010, 1'b0);
        rd(14'h0011, 1'b0);
        @(posedge clock); #1; r_addr = 14'h0012;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("credit_block_r_ready", r_ready, 0);
        end
        check("credit_block_resp_valid", resp_valid, 1);
        @(posedge clock); #1; resp_ready = 1'b1;
        rd(14'h0012, 1'b0);
        rd(14'h0013, 1'b1);
        drain(1'b0);

        // Depth-3 instance: streaming reads, one response per cycle.
        for (int k = 0; k < 8; k++) wr3(AW3'(k), 32'hC0DE_0000 | k, k == 7);
        @(posedge clock); #1;
        resp_ready3 = 1'b1; r_valid3 = 1'b1; r_addr3 = '0;
        for (int k = 0; k < 24; k++) begin
            if (k != 0) begin @(posedge clock); #1; r_addr3 = AW3'(k % 8); end
            @(negedge clock);
            check("stream_r_ready", r_ready3, 1);
            if (k >= 2) check("stream_resp_valid", resp_valid3, 1);
        end
        @(posedge clock); #1; r_valid3 = 1'b0;
        drain(1'b1);

        // Reset with two responses buffered and one read pending.
        @(posedge clock); #1; resp_ready3 = 1'b0;
        rd3(4'h1, 1'b0);
        rd3(4'h2, 1'b0);
        rd3(4'h3, 1'b0);
        check("pre_reset_resp_valid", resp_valid3, 1);
        @(posedge clock); #1;
        r_valid3 = 1'b0; reset_n3 = 1'b0;
        sbq3.delete();
        for (int i = 0; i < 2**AW3; i++) exp_mem3[i] = '0;
        #1;
        check("midrst_resp_valid", resp_valid3, 0);
        check("midrst_rw0_en", RW0_en3, 0);
        check("midrst_r_ready", r_ready3, 0);
        check("midrst_w_ready", w_ready3, 0);
        @(negedge clock);
        check("midrst_hold_resp_valid", resp_valid3, 0);
        @(posedge clock); #1; reset_n3 = 1'b1; resp_ready3 = 1'b1;
        for (int i = 0; i < 2**AW3; i++) begin
            @(negedge clock);
            check("reinit_word",
                  {RW0_en3, RW0_wmode3, w_ready3, r_ready3, resp_valid3, init_done3, RW0_addr3, RW0_wdata3},
                  {6'b110000, AW3'(i), 32'h0});
        end
        @(negedge clock);
        check("reinit_done", init_done3, 1);
        check("reinit_resp_valid", resp_valid3, 0);
        rd3(4'h3, 1'b1);
        drain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
